// File: rtl/mac_stream_if.sv
// Operand/result stream bundle for mac_stream: operand beats in, one accumulated result per vector out.
// Clock and reset stay outside the bundle as plain ports.
interface mac_stream_if #(
   parameter int DATA_W = 64,
   parameter int GUARD  = 8,
   parameter int CNT_W  = 16
) ();
   localparam int ACC_W = 2*DATA_W + GUARD;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              in_last;

   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   // Producer/consumer view of the engine.
   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_count, out_ovf
   );

   // Engine view.
   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_count, out_ovf
   );
endinterface

// File: rtl/mac_stream.sv
// Two-stage streaming multiply-accumulate: S1 multiplies, S2 accumulates and emits one result per vector.
// Last beat accepted in cycle t gives a result in t+2; a held result freezes the whole pipe and drops in_ready.
module mac_stream #(
   parameter int DATA_W = 64,
   parameter int GUARD  = 8,
   parameter bit SIGNED = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   mac_stream_if.slave  io_mac
);
   localparam int PROD_W = 2*DATA_W;
   localparam int ACC_W  = PROD_W + GUARD;

   // Pipe control
   logic w_en;
   logic w_accept;

   // S1: product register
   logic              r_s1_valid;
   logic              r_s1_last;
   logic [PROD_W-1:0] r_s1_prod;
   logic [PROD_W-1:0] w_a_ext;
   logic [PROD_W-1:0] w_b_ext;
   logic [PROD_W-1:0] w_prod;

   // S2: accumulator state
   logic              r_first;
   logic [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf;
   logic [ACC_W-1:0]  w_ext;
   logic [ACC_W-1:0]  w_base;
   logic [ACC_W:0]    w_sum_full;
   logic [ACC_W-1:0]  w_sum;
   logic              w_carry;
   logic              w_ovf_now;
   logic              w_ovf_next;
   logic [CNT_W-1:0]  w_cnt_next;

   // Result register
   logic              r_out_valid;
   logic [ACC_W-1:0]  r_out_acc;
   logic [CNT_W-1:0]  r_out_count;
   logic              r_out_ovf;

   assign w_en            = !r_out_valid | io_mac.out_ready;
   assign w_accept        = io_mac.in_valid & w_en;
   assign io_mac.in_ready = w_en;

   // Extending both operands to the product width lets a plain truncated
   // multiply give the exact signed or unsigned product.
   assign w_a_ext = {{DATA_W{SIGNED & io_mac.in_a[DATA_W-1]}}, io_mac.in_a};
   assign w_b_ext = {{DATA_W{SIGNED & io_mac.in_b[DATA_W-1]}}, io_mac.in_b};
   assign w_prod  = w_a_ext * w_b_ext;

   generate
      if (SIGNED) begin : g_sext
         assign w_ext = ACC_W'($signed(r_s1_prod));
      end else begin : g_zext
         assign w_ext = ACC_W'(r_s1_prod);
      end
   endgenerate

   assign w_base     = r_first ? '0 : r_acc;
   assign w_sum_full = {1'b0, w_base} + {1'b0, w_ext};
   assign w_sum      = w_sum_full[ACC_W-1:0];
   assign w_carry    = w_sum_full[ACC_W];

   // Signed: both addends share a sign the sum does not; unsigned: carry out.
   assign w_ovf_now  = SIGNED ? ((w_base[ACC_W-1] == w_ext[ACC_W-1]) &&
                                 (w_sum[ACC_W-1]  != w_base[ACC_W-1]))
                              : w_carry;
   assign w_ovf_next = (r_first ? 1'b0 : r_ovf) | w_ovf_now;
   assign w_cnt_next = r_first       ? CNT_W'(1) :
                       (&r_cnt)      ? r_cnt     :
                                       r_cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_last   <= 1'b0;
         r_s1_prod   <= '0;
         r_first     <= 1'b1;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_acc   <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
      end else if (w_en) begin
         r_s1_valid  <= w_accept;
         r_s1_prod   <= w_prod;
         r_s1_last   <= io_mac.in_last;
         r_out_valid <= r_s1_valid & r_s1_last;
         if (r_s1_valid) begin
            r_acc   <= w_sum;
            r_cnt   <= w_cnt_next;
            r_ovf   <= w_ovf_next;
            r_first <= r_s1_last;
            if (r_s1_last) begin
               r_out_acc   <= w_sum;
               r_out_count <= w_cnt_next;
               r_out_ovf   <= w_ovf_next;
            end
         end
      end
   end

   assign io_mac.out_valid = r_out_valid;
   assign io_mac.out_acc   = r_out_acc;
   assign io_mac.out_count = r_out_count;
   assign io_mac.out_ovf   = r_out_ovf;
endmodule
